if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, one-cycle registered fetch into IF/ID, redirect/stall handling.
// Optional fetch-address boundary check with sticky fault and HALT state: define FETCH_BOUNDARY_CHECK_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [7:0]  imem_a,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {FETCH, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        bad_addr;

`ifdef FETCH_BOUNDARY_CHECK_EN
  assign bad_addr = (pc_q[1:0] != 2'b00) || (pc_q[31:10] != 22'd0);
`else
  // Without the check, low PC bits are ignored and high bits alias through pc[9:2].
  assign bad_addr = 1'b0;
`endif

  // NOTE: every always_comb target is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          // Redirect beats stall and the address check; the in-flight word is dropped.
          pc_d    = redirect_pc;
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (!stall) begin
          if (bad_addr) begin
            state_d = HALT;
            fault_d = 1'b1;
            instr_d = NOP;
            valid_d = 1'b0;
          end else begin
            instr_d  = imem_rd;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            cnt_d    = cnt_q + 32'd1;
          end
        end
      end
      HALT: begin
        instr_d = NOP;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      pc_out_q <= 32'd0;
      valid_q  <= 1'b0;
      cnt_q    <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_a    = pc_q[9:2];
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign pc_plus4  = pc_out_q + 32'd4;
  assign valid     = valid_q;
  assign fault     = fault_q;
  assign fetch_cnt = cnt_q;

endmodule
